// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states,
// coin encoding and the coin value table.
package vend_pkg;

   localparam int unsigned MAX_CREDIT_DEF = 1000;
   localparam int unsigned PRICE_W        = 10;
   localparam int unsigned STOCK_W        = 4;
   localparam int unsigned COIN_W         = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CREDIT = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } vend_state_e;

   typedef enum logic [COIN_W-1:0] {
      COIN5   = 3'd0,
      COIN10  = 3'd1,
      COIN25  = 3'd2,
      COIN50  = 3'd3,
      COIN100 = 3'd4,
      COIN500 = 3'd5
   } coin_code_e;

   // Face value in cents; codes 6-7 are not coins and are worth nothing.
   function automatic logic [PRICE_W-1:0] coinValue(input logic [COIN_W-1:0] code);
      case (code)
         3'd0:    coinValue = 10'd5;
         3'd1:    coinValue = 10'd10;
         3'd2:    coinValue = 10'd25;
         3'd3:    coinValue = 10'd50;
         3'd4:    coinValue = 10'd100;
         3'd5:    coinValue = 10'd500;
         default: coinValue = 10'd0;
      endcase
   endfunction

endpackage

// File: rtl/change_picker.sv
// Greedy change selection: largest coin not exceeding the amount still owed.
module change_picker
   import vend_pkg::*;
#(
   parameter int unsigned CREDIT_W = 11
) (
   input  logic [CREDIT_W-1:0] amount,
   output logic [COIN_W-1:0]   code,
   output logic [PRICE_W-1:0]  value
);

   always_comb begin
      code = COIN5;
      if (32'(amount) >= 32'd500)      code = COIN500;
      else if (32'(amount) >= 32'd100) code = COIN100;
      else if (32'(amount) >= 32'd50)  code = COIN50;
      else if (32'(amount) >= 32'd25)  code = COIN25;
      else if (32'(amount) >= 32'd10)  code = COIN10;
      value = coinValue(code);
   end

endmodule

// File: rtl/vend_controller.sv
// Vending machine controller: coin credit, item selection, vend handshake
// and greedy change payout, with per-slot price/stock registers.
module vend_controller
   import vend_pkg::*;
#(
   parameter int unsigned NUM_ITEMS  = 9,
   parameter int unsigned CREDIT_W   = 11,
   parameter int unsigned MAX_CREDIT = MAX_CREDIT_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 coin_valid,
   input  logic [2:0]           coin_code,
   input  logic                 sel_valid,
   input  logic [3:0]           sel_idx,
   input  logic                 cancel,
   input  logic                 cfg_wr,
   input  logic [3:0]           cfg_idx,
   input  logic [9:0]           cfg_price,
   input  logic [3:0]           cfg_stock,
   output logic                 dispense_req,
   output logic [3:0]           dispense_idx,
   input  logic                 dispense_ack,
   output logic                 coin_out_valid,
   output logic [2:0]           coin_out_code,
   input  logic                 coin_out_ready,
   output logic [CREDIT_W-1:0]  credit,
   output logic [NUM_ITEMS-1:0] avail,
   output logic [NUM_ITEMS-1:0] oos,
   output logic                 coin_reject,
   output logic                 sel_deny,
   output logic                 busy
);

   localparam int unsigned SUM_W = CREDIT_W + 1;

   vend_state_e          state;
   logic [PRICE_W-1:0]   price [NUM_ITEMS];
   logic [STOCK_W-1:0]   stock [NUM_ITEMS];
   logic [PRICE_W-1:0]   coinOutValue;

   logic [PRICE_W-1:0]   insValue;
   logic [SUM_W-1:0]     insSum;
   logic                 insFits;
   logic                 selInRange;
   logic                 selGood;
   logic [PRICE_W-1:0]   selPrice;
   logic [STOCK_W-1:0]   selStock;
   logic                 cfgInRange;
   logic                 payHandshake;
   logic [CREDIT_W-1:0]  payRemain;
   logic [CREDIT_W-1:0]  pickAmount;
   logic [COIN_W-1:0]    pickCode;
   logic [PRICE_W-1:0]   pickValue;

   // Insertion, selection and payout arithmetic, all kept within the credit ceiling.
   always_comb begin
      insValue   = coinValue(coin_code);
      insSum     = SUM_W'(credit) + SUM_W'(insValue);
      insFits    = (coin_code <= 3'd5) && (insSum <= SUM_W'(MAX_CREDIT));
      selInRange = 32'(sel_idx) < NUM_ITEMS;
      cfgInRange = 32'(cfg_idx) < NUM_ITEMS;
      selPrice   = '0;
      selStock   = '0;
      if (selInRange) begin
         selPrice = price[sel_idx];
         selStock = stock[sel_idx];
      end
      selGood      = selInRange && (selStock != '0) && (SUM_W'(credit) >= SUM_W'(selPrice));
      payHandshake = coin_out_valid && coin_out_ready;
      payRemain    = credit - CREDIT_W'(coinOutValue);
      pickAmount   = payHandshake ? payRemain : credit;
   end

   // Picker looks one coin ahead during a handshake so payout runs at one coin per cycle.
   change_picker #(.CREDIT_W(CREDIT_W)) u_picker (
      .amount(pickAmount),
      .code  (pickCode),
      .value (pickValue)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         credit         <= '0;
         dispense_req   <= 1'b0;
         dispense_idx   <= '0;
         coin_out_valid <= 1'b0;
         coin_out_code  <= '0;
         coinOutValue   <= '0;
         coin_reject    <= 1'b0;
         sel_deny       <= 1'b0;
         for (int i = 0; i < int'(NUM_ITEMS); i++) begin
            price[i] <= '0;
            stock[i] <= '0;
         end
      end else begin
         coin_reject <= 1'b0;
         sel_deny    <= 1'b0;
         case (state)
            IDLE, CREDIT: begin
               if (cancel) begin
                  if (state == CREDIT) state <= CHANGE;
                  if (coin_valid) coin_reject <= 1'b1;
               end else if (sel_valid) begin
                  if (state == CREDIT && selGood) begin
                     credit       <= credit - CREDIT_W'(selPrice);
                     state        <= VEND;
                     dispense_req <= 1'b1;
                     dispense_idx <= sel_idx;
                  end else begin
                     sel_deny <= 1'b1;
                  end
                  if (coin_valid) coin_reject <= 1'b1;
               end else if (coin_valid) begin
                  if (insFits) begin
                     credit <= CREDIT_W'(insSum);
                     state  <= CREDIT;
                  end else begin
                     coin_reject <= 1'b1;
                  end
               end
               if (state == IDLE && cfg_wr && cfgInRange) begin
                  price[cfg_idx] <= cfg_price;
                  stock[cfg_idx] <= cfg_stock;
               end
            end
            VEND: begin
               if (coin_valid) coin_reject <= 1'b1;
               if (dispense_ack) begin
                  if (stock[dispense_idx] != '0)
                     stock[dispense_idx] <= stock[dispense_idx] - STOCK_W'(1);
                  dispense_req <= 1'b0;
                  state        <= (credit != '0) ? CHANGE : IDLE;
               end
            end
            CHANGE: begin
               if (coin_valid) coin_reject <= 1'b1;
               if (!coin_out_valid) begin
                  if (credit == '0) begin
                     state <= IDLE;
                  end else begin
                     coin_out_valid <= 1'b1;
                     coin_out_code  <= pickCode;
                     coinOutValue   <= pickValue;
                  end
               end else if (payHandshake) begin
                  credit <= payRemain;
                  if (payRemain == '0) begin
                     coin_out_valid <= 1'b0;
                     state          <= IDLE;
                  end else begin
                     coin_out_code <= pickCode;
                     coinOutValue  <= pickValue;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Lamps follow the registered credit/price/stock; green only while accepting selections.
   always_comb begin
      for (int i = 0; i < int'(NUM_ITEMS); i++) begin
         oos[i]   = (stock[i] == '0);
         avail[i] = (state == IDLE || state == CREDIT) && (stock[i] != '0) &&
                    (SUM_W'(credit) >= SUM_W'(price[i]));
      end
   end

   assign busy = (state == VEND) || (state == CHANGE);

endmodule
